// File: rtl/intra_pkg.sv
// intra_pkg: constants and encodings used by the 16x16 intra-prediction
// reconstruction block (intra16_recon) and its add/clip datapath.
//   BLK / PIX_W / RES_W : default block edge, pixel width, residual width
//   DEF_PIX             : value used for a missing neighbour / DC fallback
//   mode_e              : prediction mode encoding on the 'mode' port
//   state_e             : control FSM states
package intra_pkg;

  localparam int BLK     = 16;
  localparam int PIX_W   = 8;
  localparam int RES_W   = 9;
  localparam int DEF_PIX = 128;

  typedef enum logic [1:0] {
    MODE_VER = 2'd0,
    MODE_HOR = 2'd1,
    MODE_DC  = 2'd2,
    MODE_RSV = 2'd3   // reserved; handled as DC
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DC_ACC = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/intra16_clip_add.sv
// intra16_clip_add: combinational per-lane reconstruction for one row.
//   pred : BLK unsigned predicted pixels
//   res  : BLK signed residuals, lane i at [i*RES_W +: RES_W]
//   rec  : BLK pixels, clip(pred + res, 0, 2^PIX_W-1)
// The sum is formed at PIX_W+2 signed bits, which covers
// (0..2^PIX_W-1) + (-2^(RES_W-1)..2^(RES_W-1)-1) for RES_W <= PIX_W+1.
module intra16_clip_add #(
  parameter int BLK   = intra_pkg::BLK,
  parameter int PIX_W = intra_pkg::PIX_W,
  parameter int RES_W = intra_pkg::RES_W
) (
  input  logic [BLK-1:0][PIX_W-1:0] pred,
  input  logic [BLK*RES_W-1:0]      res,
  output logic [BLK-1:0][PIX_W-1:0] rec
);

  localparam int SW = PIX_W + 2;

  for (genvar i = 0; i < BLK; i++) begin : g_lane
    logic signed [SW-1:0] sum;

    assign sum = $signed({2'b00, pred[i]}) + SW'($signed(res[i*RES_W +: RES_W]));

    // negative -> 0; any bit above the pixel range while positive -> saturate
    always_comb begin
      if (sum[SW-1])               rec[i] = '0;
      else if (sum[SW-2])          rec[i] = '1;
      else                         rec[i] = sum[PIX_W-1:0];
    end
  end

endmodule

// File: rtl/intra16_recon.sv
// intra16_recon: reconstructs a BLKxBLK intra block one row per cycle.
// A start in IDLE latches mode, neighbour availability and neighbour pixels.
// DC modes first spend BLK cycles summing the neighbours, then every mode
// streams: each accepted residual row is added to the prediction, clipped,
// and presented on rec_row one cycle later under a valid/ready handshake.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   start, mode                : block request and prediction mode
//   top_avail, left_avail      : neighbour validity
//   toppixels, leftpixels      : neighbour row / column, pixel i at [8i+:8]
//   res_valid/res_ready/res_row: residual row input handshake
//   rec_valid/rec_ready/rec_row: reconstructed row output handshake
//   rec_last                   : marks the final row of the block
//   busy, done                 : not idle / one-cycle end-of-block pulse
module intra16_recon #(
  parameter int BLK   = intra_pkg::BLK,
  parameter int PIX_W = intra_pkg::PIX_W,
  parameter int RES_W = intra_pkg::RES_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic                 top_avail,
  input  logic                 left_avail,
  input  logic [BLK*PIX_W-1:0] toppixels,
  input  logic [BLK*PIX_W-1:0] leftpixels,
  input  logic                 res_valid,
  output logic                 res_ready,
  input  logic [BLK*RES_W-1:0] res_row,
  output logic                 rec_valid,
  input  logic                 rec_ready,
  output logic [BLK*PIX_W-1:0] rec_row,
  output logic                 rec_last,
  output logic                 busy,
  output logic                 done
);

  import intra_pkg::*;

  localparam int CW    = $clog2(BLK);
  localparam int ACC_W = PIX_W + CW;
  localparam logic [ACC_W:0]   RND_BOTH = (ACC_W+1)'(BLK);
  localparam logic [ACC_W:0]   RND_ONE  = (ACC_W+1)'(BLK / 2);
  localparam logic [PIX_W-1:0] DEF      = PIX_W'(DEF_PIX);
  localparam logic [CW-1:0]    LAST_IDX = CW'(BLK - 1);

  state_e                   state_q, state_d;
  mode_e                    mode_q, mode_d;
  logic                     top_av_q, top_av_d;
  logic                     left_av_q, left_av_d;
  logic [BLK-1:0][PIX_W-1:0] top_q, top_d;
  logic [BLK-1:0][PIX_W-1:0] left_q, left_d;
  // cnt is the accumulation step in DC_ACC and the residual row index in STREAM
  logic [CW-1:0]            cnt_q, cnt_d;
  // set once the final residual row has been taken; closes res_ready
  logic                     taken_all_q, taken_all_d;
  logic [ACC_W-1:0]         sum_t_q, sum_t_d;
  logic [ACC_W-1:0]         sum_l_q, sum_l_d;
  logic                     rec_valid_q, rec_valid_d;
  logic                     rec_last_q, rec_last_d;
  logic [BLK-1:0][PIX_W-1:0] rec_q, rec_d;

  logic [PIX_W-1:0]          dc_val;
  logic [BLK-1:0][PIX_W-1:0] pred;
  logic [BLK-1:0][PIX_W-1:0] rec_sum;
  logic                      res_fire, rec_fire;

  // DC value from the finished accumulators; rounding adds half the divisor
  always_comb begin
    dc_val = DEF;
    unique case ({top_av_q, left_av_q})
      2'b11:   dc_val = PIX_W'(({1'b0, sum_t_q} + {1'b0, sum_l_q} + RND_BOTH) >> (CW + 1));
      2'b10:   dc_val = PIX_W'(({1'b0, sum_t_q} + RND_ONE) >> CW);
      2'b01:   dc_val = PIX_W'(({1'b0, sum_l_q} + RND_ONE) >> CW);
      default: dc_val = DEF;
    endcase
  end

  always_comb begin
    pred = '0;
    for (int c = 0; c < BLK; c++) begin
      unique case (mode_q)
        MODE_VER: pred[c] = top_av_q  ? top_q[c]      : DEF;
        MODE_HOR: pred[c] = left_av_q ? left_q[cnt_q] : DEF;
        default:  pred[c] = dc_val;
      endcase
    end
  end

  intra16_clip_add #(
    .BLK   (BLK),
    .PIX_W (PIX_W),
    .RES_W (RES_W)
  ) u_clip_add (
    .pred (pred),
    .res  (res_row),
    .rec  (rec_sum)
  );

  assign res_ready = (state_q == ST_STREAM) && !taken_all_q && (!rec_valid_q || rec_ready);
  assign res_fire  = res_valid && res_ready;
  assign rec_fire  = rec_valid_q && rec_ready;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    top_av_d    = top_av_q;
    left_av_d   = left_av_q;
    top_d       = top_q;
    left_d      = left_q;
    cnt_d       = cnt_q;
    taken_all_d = taken_all_q;
    sum_t_d     = sum_t_q;
    sum_l_d     = sum_l_q;
    rec_valid_d = rec_valid_q;
    rec_last_d  = rec_last_q;
    rec_d       = rec_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d      = mode_e'(mode);
          top_av_d    = top_avail;
          left_av_d   = left_avail;
          top_d       = toppixels;
          left_d      = leftpixels;
          cnt_d       = '0;
          taken_all_d = 1'b0;
          sum_t_d     = '0;
          sum_l_d     = '0;
          state_d     = mode[1] ? ST_DC_ACC : ST_STREAM;
        end
      end

      ST_DC_ACC: begin
        sum_t_d = sum_t_q + ACC_W'(top_q[cnt_q]);
        sum_l_d = sum_l_q + ACC_W'(left_q[cnt_q]);
        cnt_d   = cnt_q + 1'b1;   // wraps to 0, ready for row indexing
        if (cnt_q == LAST_IDX) state_d = ST_STREAM;
      end

      ST_STREAM: begin
        if (rec_fire) begin
          rec_valid_d = 1'b0;
          rec_last_d  = 1'b0;
        end
        // a new row may replace the one leaving in the same cycle
        if (res_fire) begin
          rec_d       = rec_sum;
          rec_valid_d = 1'b1;
          rec_last_d  = (cnt_q == LAST_IDX);
          cnt_d       = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) taken_all_d = 1'b1;
        end
        if (taken_all_q && rec_fire && rec_last_q) state_d = ST_DONE;
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_VER;
      top_av_q    <= 1'b0;
      left_av_q   <= 1'b0;
      top_q       <= '0;
      left_q      <= '0;
      cnt_q       <= '0;
      taken_all_q <= 1'b0;
      sum_t_q     <= '0;
      sum_l_q     <= '0;
      rec_valid_q <= 1'b0;
      rec_last_q  <= 1'b0;
      rec_q       <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      top_av_q    <= top_av_d;
      left_av_q   <= left_av_d;
      top_q       <= top_d;
      left_q      <= left_d;
      cnt_q       <= cnt_d;
      taken_all_q <= taken_all_d;
      sum_t_q     <= sum_t_d;
      sum_l_q     <= sum_l_d;
      rec_valid_q <= rec_valid_d;
      rec_last_q  <= rec_last_d;
      rec_q       <= rec_d;
    end
  end

  assign rec_valid = rec_valid_q;
  assign rec_last  = rec_last_q;
  assign rec_row   = rec_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_intra16_recon.sv
// Scoreboard bench for intra16_recon. The driver computes each expected row
// from the prediction rules at the moment the residual row is handed over
// and pushes it; an independent monitor pops and compares whenever a row is
// accepted on the output side, and also owns rec_ready (random, forced or
// stalled).
module tb_intra16_recon;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [1:0]   mode;
  logic         top_avail, left_avail;
  logic [127:0] toppixels, leftpixels;
  logic         res_valid, res_ready;
  logic [143:0] res_row;
  logic         rec_valid, rec_ready;
  logic [127:0] rec_row;
  logic         rec_last, busy, done;

  always #5 clk = ~clk;

  intra16_recon dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .top_avail  (top_avail),
    .left_avail (left_avail),
    .toppixels  (toppixels),
    .leftpixels (leftpixels),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_row    (res_row),
    .rec_valid  (rec_valid),
    .rec_ready  (rec_ready),
    .rec_row    (rec_row),
    .rec_last   (rec_last),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic [127:0] row;
    logic         last;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   top_a[16];
  int   left_a[16];
  int   res_a[16][16];
  int   blk_id = 0;
  int   stall_blk = -1;
  bit   force_rdy = 1'b0;
  int   done_cnt = 0;
  int   rows_seen = 0;
  int   stall_cnt = 0;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int clamp(int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  task automatic rand_fill();
    for (int i = 0; i < 16; i++) begin
      top_a[i]  = $urandom_range(0, 255);
      left_a[i] = $urandom_range(0, 255);
      for (int j = 0; j < 16; j++) res_a[i][j] = int'($urandom_range(0, 511)) - 256;
    end
  endtask

  task automatic chk_reset_outs();
    chk("reset_ctrl_outs", {123'd0, rec_valid, rec_last, res_ready, busy, done}, 128'd0);
    chk("reset_rec_row", rec_row, 128'd0);
  endtask

  // Runs one block. abort_row >= 0 applies reset instead of offering that row.
  task automatic run_block(int m, bit tav, bit lav, int abort_row);
    logic [127:0] tp, lp, er;
    logic [143:0] rr;
    int st, sl, dc, p, lat, to, d0;
    st = 0; sl = 0;
    for (int c = 0; c < 16; c++) begin
      tp[c*8 +: 8] = 8'(top_a[c]);
      lp[c*8 +: 8] = 8'(left_a[c]);
      st += top_a[c];
      sl += left_a[c];
    end
    if (tav && lav) dc = (st + sl + 16) / 32;
    else if (tav)   dc = (st + 8) / 16;
    else if (lav)   dc = (sl + 8) / 16;
    else            dc = 128;
    d0 = done_cnt;

    @(posedge clk); #1;
    start = 1'b1; mode = 2'(m); top_avail = tav; left_avail = lav;
    toppixels = tp; leftpixels = lp;
    blk_id++;
    @(posedge clk); #1;
    // latched copies must be used from here on
    start = 1'b0; mode = 2'($urandom); top_avail = 1'($urandom); left_avail = 1'($urandom);
    toppixels = {$urandom, $urandom, $urandom, $urandom};
    leftpixels = {$urandom, $urandom, $urandom, $urandom};

    lat = 1;
    @(negedge clk);
    while (!res_ready && lat < 100) begin @(negedge clk); lat++; end
    chk("first_row_latency", 128'(lat), 128'((m >= 2) ? 17 : 1));

    for (int r = 0; r < 16; r++) begin
      if (r == abort_row) begin
        #1;
        reset = 1'b1; res_valid = 1'b0; sb.delete();
        @(negedge clk);
        chk_reset_outs();
        #1 reset = 1'b0;
        return;
      end
      for (int c = 0; c < 16; c++) begin
        if (m == 0)      p = tav ? top_a[c] : 128;
        else if (m == 1) p = lav ? left_a[r] : 128;
        else             p = dc;
        rr[c*9 +: 9] = 9'(res_a[r][c]);
        er[c*8 +: 8] = 8'(clamp(p + res_a[r][c]));
      end
      res_row = rr; res_valid = 1'b1; to = 0;
      while (!res_ready && to < 500) begin
        @(negedge clk); to++;
        // a start pulse landing mid-block must be ignored
        start = (stall_cnt == 3);
        if (start) mode = 2'd1;
      end
      start = 1'b0;
      if (to >= 500) begin
        chk("res_ready_timeout", 128'd1, 128'd0);
        res_valid = 1'b0;
        return;
      end
      sb.push_back('{row: er, last: (r == 15)});
      @(negedge clk);
    end
    res_valid = 1'b0;

    to = 0;
    while (done_cnt == d0 && to < 1000) begin @(negedge clk); to++; end
    chk("block_completes", 128'(done_cnt - d0), 128'd1);
    @(negedge clk);
  endtask

  // monitor + consumer
  initial begin
    bit           pv, pend, post;
    logic [127:0] prow;
    logic         plast;
    int           last_stalled;
    exp_t         e;
    pv = 0; pend = 0; post = 0; prow = '0; plast = 1'b0; last_stalled = -1;
    rec_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pv = 0; pend = 0; post = 0; rows_seen = 0; stall_cnt = 0;
      end else begin
        if (pv) begin
          chk("hold_valid", 128'(rec_valid), 128'd1);
          chk("hold_row", rec_row, prow);
          chk("hold_last", 128'(rec_last), 128'(plast));
        end
        if (rec_valid && !rec_ready) chk("res_ready_low_in_stall", 128'(res_ready), 128'd0);
        if (post) begin
          chk("done_clear", {126'd0, done, busy}, 128'd0);
          post = 0;
        end
        if (pend) begin
          chk("done_pulse", {126'd0, done, busy}, 128'd3);
          pend = 0; post = 1; done_cnt++;
        end
        if (rec_valid && rec_ready) begin
          if (sb.size() == 0) chk("unexpected_row", 128'd1, 128'd0);
          else begin
            e = sb.pop_front();
            chk("rec_row", rec_row, e.row);
            chk("rec_last", 128'(rec_last), 128'(e.last));
            rows_seen++;
            if (e.last) begin pend = 1; rows_seen = 0; end
          end
        end
        pv = rec_valid && !rec_ready; prow = rec_row; plast = rec_last;
      end
      @(posedge clk); #1;
      if (stall_cnt > 0) begin
        rec_ready = 1'b0; stall_cnt--;
      end else if (stall_blk == blk_id && last_stalled != blk_id && rows_seen == 3 && rec_valid) begin
        last_stalled = blk_id; stall_cnt = 4; rec_ready = 1'b0;
      end else begin
        rec_ready = force_rdy ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; mode = 2'd0; top_avail = 1'b0; left_avail = 1'b0;
    toppixels = '0; leftpixels = '0; res_valid = 1'b0; res_row = '0;
    repeat (3) @(negedge clk);
    chk_reset_outs();
    #1 reset = 1'b0;

    // vertical ramp plus constant residual, consumer always ready
    rand_fill();
    force_rdy = 1'b1;
    for (int c = 0; c < 16; c++) top_a[c] = c * 10;
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) res_a[r][c] = 5;
    run_block(0, 1'b1, 1'b1, -1);
    force_rdy = 1'b0;

    // DC with both neighbours: (1600 + 960 + 16) >> 5 = 80
    for (int i = 0; i < 16; i++) begin top_a[i] = 100; left_a[i] = 60; end
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) res_a[r][c] = 0;
    run_block(2, 1'b1, 1'b1, -1);

    // horizontal without left neighbours: prediction 128, low clip
    rand_fill();
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) res_a[r][c] = r * 20 - 200;
    run_block(1, 1'b1, 1'b0, -1);

    // both clip ends: 250+20 -> 255, 250-256 -> 0
    rand_fill();
    for (int c = 0; c < 16; c++) top_a[c] = 250;
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) res_a[r][c] = (c % 2 == 0) ? 20 : -256;
    run_block(0, 1'b1, 1'b1, -1);

    // consumer stalls on row 3 for 5 cycles, start pulsed meanwhile
    rand_fill();
    stall_blk = blk_id + 1;
    run_block(0, 1'b1, 1'b1, -1);

    // reset mid-block, then a fresh vertical block
    rand_fill();
    run_block(0, 1'b1, 1'b1, 8);
    repeat (6) @(negedge clk);
    chk("idle_after_abort", {126'd0, rec_valid, busy}, 128'd0);
    rand_fill();
    run_block(0, 1'b1, 1'b1, -1);

    // random modes and availability
    repeat (10) begin
      rand_fill();
      run_block(int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), -1);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 128'(sb.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
